// File: rtl/trg_mon_pkg.sv
// ============================================================================
// Module  : trg_mon_pkg
// Brief   : Shared types and constants for the trigger monitor snapshot block
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package trg_mon_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 16'heb90;
    localparam logic [WORD_W-1:0] BACKUP0_DEF   = 16'h5aa5;
    localparam logic [WORD_W-1:0] BACKUP1_DEF   = 16'heb90;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        SEQ  = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/trg_mon_frame_tx.sv
// ============================================================================
// Module  : trg_mon_frame_tx
// Brief   : Framed snapshot streamer: FSM, word index, checksum, handshake
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module trg_mon_frame_tx
    import trg_mon_pkg::*;
#(
    parameter int                NUM_WORDS = 36,
    parameter int                IDX_W     = $clog2(NUM_WORDS),
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_start,
    input  logic              i_capture,
    input  logic [WORD_W-1:0] i_seq,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_ready,
    output logic [IDX_W-1:0]  o_idx,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_busy
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_WORDS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [WORD_W-1:0] r_sum;
    logic              r_busy;
    logic              w_accept;

    // Outputs decode only registered state, so they hold while stalled.
    always_comb begin
        o_data  = '0;
        o_valid = 1'b1;
        o_last  = 1'b0;
        case (r_state)
            IDLE:    o_valid = 1'b0;
            SYNC:    o_data  = SYNC_WORD;
            SEQ:     o_data  = i_seq;
            DATA:    o_data  = i_word;
            CHK: begin
                o_data = r_sum;
                o_last = 1'b1;
            end
            default: o_valid = 1'b0;
        endcase
    end

    assign w_accept = o_valid & i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: if (i_frame_start) w_state_nxt = SYNC;
            SYNC: if (w_accept) w_state_nxt = SEQ;
            SEQ: begin
                if (w_accept) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (w_accept) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = CHK;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            CHK:  if (w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (i_capture) begin
                r_sum <= '0;
            end else if (w_accept && (r_state == SEQ || r_state == DATA)) begin
                r_sum <= r_sum + o_data;
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/trg_mon_snapshot.sv
// ============================================================================
// Module  : trg_mon_snapshot
// Brief   : Monitor-word snapshot with random-read port and framed stream
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module trg_mon_snapshot
    import trg_mon_pkg::*;
#(
    parameter int                NUM_WORDS = 36,
    parameter int                ADDR_W    = 8,
    parameter int                BASE_ADDR = 2,
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter logic [WORD_W-1:0] BACKUP0   = BACKUP0_DEF,
    parameter logic [WORD_W-1:0] BACKUP1   = BACKUP1_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        store_en,
    input  logic [NUM_WORDS*WORD_W-1:0] mon_bus_in,
    input  logic                        rd_in,
    input  logic [ADDR_W-1:0]           rd_addr_in,
    output logic [WORD_W-1:0]           mon_data_out,
    input  logic                        frame_start_in,
    output logic [WORD_W-1:0]           frm_data_out,
    output logic                        frm_valid_out,
    input  logic                        frm_ready_in,
    output logic                        frm_last_out,
    output logic                        busy_out,
    output logic [WORD_W-1:0]           snap_cnt_out,
    output logic [7:0]                  miss_cnt_out
);

    localparam int c_idx_w = $clog2(NUM_WORDS);

    logic [WORD_W-1:0]  r_snap [NUM_WORDS];
    logic [WORD_W-1:0]  r_snap_cnt;
    logic [7:0]         r_miss_cnt;
    logic [WORD_W-1:0]  r_rd_data;
    logic [c_idx_w-1:0] w_idx;
    logic               w_req;
    logic               w_capture;
    logic               w_rd_hit;
    logic [WORD_W-1:0]  w_rd_word;

    assign w_req     = store_en | frame_start_in;
    assign w_capture = w_req & ~busy_out;

    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_addr_in == ADDR_W'(BASE_ADDR + i)) begin
                w_rd_hit  = 1'b1;
                w_rd_word = r_snap[i];
            end
        end
        if (rd_addr_in == ADDR_W'(BASE_ADDR + NUM_WORDS)) begin
            w_rd_hit  = 1'b1;
            w_rd_word = BACKUP0;
        end
        if (rd_addr_in == ADDR_W'(BASE_ADDR + NUM_WORDS + 1)) begin
            w_rd_hit  = 1'b1;
            w_rd_word = BACKUP1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_WORDS; i++) r_snap[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < NUM_WORDS; i++) r_snap[i] <= mon_bus_in[i*WORD_W +: WORD_W];
        end
    end

    // Unmapped read addresses leave the read register untouched.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_snap_cnt <= '0;
            r_miss_cnt <= '0;
            r_rd_data  <= '0;
        end else begin
            if (w_capture) r_snap_cnt <= r_snap_cnt + 1'b1;
            if (busy_out && w_req && r_miss_cnt != 8'hFF) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (rd_in && w_rd_hit) r_rd_data <= w_rd_word;
        end
    end

    trg_mon_frame_tx #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (c_idx_w),
        .SYNC_WORD (SYNC_WORD)
    ) u_frame_tx (
        .clk           (clk_in),
        .rst           (rst_in),
        .i_frame_start (frame_start_in),
        .i_capture     (w_capture),
        .i_seq         (r_snap_cnt),
        .i_word        (r_snap[w_idx]),
        .i_ready       (frm_ready_in),
        .o_idx         (w_idx),
        .o_data        (frm_data_out),
        .o_valid       (frm_valid_out),
        .o_last        (frm_last_out),
        .o_busy        (busy_out)
    );

    assign mon_data_out = r_rd_data;
    assign snap_cnt_out = r_snap_cnt;
    assign miss_cnt_out = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trg_mon_snapshot.sv
// ============================================================================
// Module  : tb_trg_mon_snapshot
// Brief   : Scoreboard bench for trg_mon_snapshot (NUM_WORDS = 4)
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trg_mon_snapshot;

    localparam int NW = 4;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           store_en;
    logic [NW*16-1:0] mon_bus_in;
    logic           rd_in;
    logic [7:0]     rd_addr_in;
    logic [15:0]    mon_data_out;
    logic           frame_start_in;
    logic [15:0]    frm_data_out;
    logic           frm_valid_out;
    logic           frm_ready_in;
    logic           frm_last_out;
    logic           busy_out;
    logic [15:0]    snap_cnt_out;
    logic [7:0]     miss_cnt_out;

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];
    logic [15:0] rd_q[$];

    always #5 clk_in = ~clk_in;

    trg_mon_snapshot #(
        .NUM_WORDS (NW),
        .ADDR_W    (8),
        .BASE_ADDR (2),
        .SYNC_WORD (16'heb90),
        .BACKUP0   (16'h5aa5),
        .BACKUP1   (16'heb90)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .store_en       (store_en),
        .mon_bus_in     (mon_bus_in),
        .rd_in          (rd_in),
        .rd_addr_in     (rd_addr_in),
        .mon_data_out   (mon_data_out),
        .frame_start_in (frame_start_in),
        .frm_data_out   (frm_data_out),
        .frm_valid_out  (frm_valid_out),
        .frm_ready_in   (frm_ready_in),
        .frm_last_out   (frm_last_out),
        .busy_out       (busy_out),
        .snap_cnt_out   (snap_cnt_out),
        .miss_cnt_out   (miss_cnt_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_w(input logic [15:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic push_frame(input logic [15:0] seq, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] chk);
        push_w(16'heb90, 1'b0);
        push_w(seq, 1'b0);
        push_w(w0, 1'b0);
        push_w(w1, 1'b0);
        push_w(w2, 1'b0);
        push_w(w3, 1'b0);
        push_w(chk, 1'b1);
    endtask

    task automatic do_reset();
        rst_in         = 1'b1;
        store_en       = 1'b0;
        frame_start_in = 1'b0;
        rd_in          = 1'b0;
        frm_ready_in   = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        exp_q.delete();
        rd_q.delete();
    endtask

    task automatic rd(input logic [7:0] addr, input logic [15:0] exp);
        rd_in      = 1'b1;
        rd_addr_in = addr;
        rd_q.push_back(exp);
        tick();
        rd_in = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy_out && n < max_cyc) begin
            tick();
            n++;
        end
        check("frame_done", {31'd0, busy_out}, 32'd0);
        check("frame_q_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compares read data and accepted stream words against the queues.
    initial begin
        logic        rd_s;
        logic        prev_hold;
        logic [16:0] prev_w;
        logic [16:0] e;
        prev_hold = 1'b0;
        prev_w    = '0;
        forever begin
            @(posedge clk_in);
            rd_s = rd_in;
            @(negedge clk_in);
            if (rd_s) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_unexpected: got %h expected no read", mon_data_out);
                end else begin
                    check("rd_data", {16'd0, mon_data_out}, {16'd0, rd_q.pop_front()});
                end
            end
            if (prev_hold)
                check("hold_stable", {frm_valid_out, frm_last_out, frm_data_out}, {1'b1, prev_w});
            if (frm_valid_out && frm_ready_in && !rst_in) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frm_unexpected: got %h expected no word", {frm_last_out, frm_data_out});
                end else begin
                    e = exp_q.pop_front();
                    check("frm_word", {frm_last_out, frm_data_out}, e);
                end
            end
            prev_hold = frm_valid_out & ~frm_ready_in & ~rst_in;
            prev_w    = {frm_last_out, frm_data_out};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        mon_bus_in = '0;
        rd_addr_in = '0;
        do_reset();
        check("rst_valid", {31'd0, frm_valid_out}, 32'd0);
        check("rst_last", {31'd0, frm_last_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_snap_cnt", {16'd0, snap_cnt_out}, 32'd0);
        check("rst_miss_cnt", {24'd0, miss_cnt_out}, 32'd0);
        check("rst_mon_data", {16'd0, mon_data_out}, 32'd0);

        // Capture and random read
        mon_bus_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        store_en   = 1'b1;
        tick();
        store_en   = 1'b0;
        mon_bus_in = {4{16'hdead}};
        rd(8'd2, 16'h1111);
        rd(8'd3, 16'h2222);
        rd(8'd4, 16'h3333);
        rd(8'd5, 16'h4444);
        rd(8'd6, 16'h5aa5);
        rd(8'd7, 16'heb90);
        rd(8'd0, 16'heb90);
        tick();
        check("t1_rd_hold", {16'd0, mon_data_out}, 32'h0000eb90);
        check("t1_snap_cnt", {16'd0, snap_cnt_out}, 32'd1);

        // Frame with ready tied high
        do_reset();
        mon_bus_in = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        push_frame(16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000b);
        check("t2_pre_valid", {31'd0, frm_valid_out}, 32'd0);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        n = 0;
        while (busy_out && n < 50) begin
            check("t2_valid", {31'd0, frm_valid_out}, 32'd1);
            n++;
            tick();
        end
        check("t2_len", n, 32'd7);
        check("t2_valid_gap", {31'd0, frm_valid_out}, 32'd0);
        check("t2_q_empty", exp_q.size(), 32'd0);

        // Backpressure: ready toggles every cycle
        do_reset();
        push_frame(16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000b);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        n = 0;
        while (busy_out && n < 60) begin
            frm_ready_in = ~frm_ready_in;
            tick();
            n++;
        end
        frm_ready_in = 1'b1;
        check("t3_done", {31'd0, busy_out}, 32'd0);
        check("t3_q_empty", exp_q.size(), 32'd0);

        // Requests while busy are rejected and counted
        push_frame(16'h0002, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000c);
        frm_ready_in   = 1'b0;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        mon_bus_in     = {4{16'h9999}};
        store_en       = 1'b1;
        tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        store_en = 1'b0;
        check("t4_miss3", {24'd0, miss_cnt_out}, 32'd3);
        check("t4_snap_cnt", {16'd0, snap_cnt_out}, 32'd2);
        rd(8'd2, 16'h0001);
        rd(8'd5, 16'h0004);
        tick();
        store_en = 1'b1;
        repeat (300) tick();
        store_en = 1'b0;
        check("t4_miss_sat", {24'd0, miss_cnt_out}, 32'd255);
        check("t4_snap_cnt2", {16'd0, snap_cnt_out}, 32'd2);
        frm_ready_in = 1'b1;
        wait_idle(40);

        // Sequence wrap and checksum overflow
        do_reset();
        mon_bus_in = {4{16'hffff}};
        store_en   = 1'b1;
        repeat (65535) tick();
        store_en = 1'b0;
        check("t5_cnt_ffff", {16'd0, snap_cnt_out}, 32'h0000ffff);
        push_frame(16'h0000, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hfffc);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        wait_idle(40);
        check("t5_cnt_wrap", {16'd0, snap_cnt_out}, 32'd0);

        // Reset in the middle of DATA
        mon_bus_in = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
        push_w(16'heb90, 1'b0);
        push_w(16'h0001, 1'b0);
        push_w(16'h0005, 1'b0);
        frame_start_in = 1'b1;
        rd_in          = 1'b1;
        rd_addr_in     = 8'd6;
        rd_q.push_back(16'h5aa5);
        tick();
        frame_start_in = 1'b0;
        rd_in          = 1'b0;
        tick();
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        check("t6_valid", {31'd0, frm_valid_out}, 32'd0);
        check("t6_busy", {31'd0, busy_out}, 32'd0);
        check("t6_snap_cnt", {16'd0, snap_cnt_out}, 32'd0);
        check("t6_mon_data", {16'd0, mon_data_out}, 32'd0);
        check("t6_q_empty", exp_q.size(), 32'd0);
        rst_in = 1'b0;
        tick();
        push_frame(16'h0001, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h001b);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        wait_idle(40);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
